// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and helpers for the iterative signed multiply/divide engine.
// Imported by the engine and by anything that drives it.
package mult_div_unit_pkg;

  localparam logic [1:0] MD_MUL = 2'b01;
  localparam logic [1:0] MD_DIV = 2'b10;

  // Quotient reported when the divisor is zero (all ones).
  localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } stateT;

  function automatic logic isLegalOp(input logic [1:0] opSel);
    return (opSel == MD_MUL) || (opSel == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the control unit (master) and the
// multiply/divide engine (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             stall;

  modport master (
    output start, op_sel, op_a, op_b,
    input  result_lo, result_hi, busy, done, div_by_zero, stall
  );

  modport slave (
    input  start, op_sel, op_a, op_b,
    output result_lo, result_hi, busy, done, div_by_zero, stall
  );

endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's complement: result = neg ? -value : value.
// Used for operand magnitudes at capture and for sign-correcting results.
module mult_div_unit_sign_fix #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  logic [W-1:0] inverted;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_inv
      assign inverted[gi] = value[gi] ^ neg;
    end
  endgenerate

  assign result = inverted + {{(W-1){1'b0}}, neg};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed WIDTHxWIDTH multiply / WIDTH/WIDTH divide engine. Works on
// operand magnitudes one bit per cycle and sign-corrects when loading hi/lo.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CNT_BITS = 5
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);

  localparam int                  ACC_W    = 2*WIDTH + 1;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] SAT_CNT  = CNT_BITS'(WIDTH);

  stateT               stateReg, stateNext;
  logic [CNT_BITS-1:0] cntReg;
  logic [ACC_W-1:0]    accReg;
  logic [WIDTH-1:0]    opndReg;
  logic                isMulReg;
  logic                signAReg;
  logic                signBReg;
  logic [WIDTH-1:0]    resultLoReg;
  logic [WIDTH-1:0]    resultHiReg;
  logic                divByZeroReg;

  logic                accept;
  logic                divZero;
  logic                isMulIn;
  logic                lastIter;
  logic [WIDTH-1:0]    absA, absB;
  logic [ACC_W-1:0]    accInit, accNext;
  logic [WIDTH:0]      mulSum;
  logic [ACC_W-1:0]    mulStep;
  logic [ACC_W-1:0]    divShifted;
  logic [WIDTH:0]      divShiftHi, divDiff;
  logic                divFits;
  logic [ACC_W-1:0]    divStep;
  logic [2*WIDTH-1:0]  prodFixed;
  logic [WIDTH-1:0]    quotFixed, remFixed;

  assign isMulIn  = (bus.op_sel == MD_MUL);
  assign accept   = bus.start & isLegalOp(bus.op_sel) & (stateReg != S_RUN);
  assign divZero  = (bus.op_sel == MD_DIV) && (bus.op_b == '0);
  assign lastIter = (cntReg == LAST_CNT);

  mult_div_unit_sign_fix #(.W(WIDTH)) uAbsA (
    .value  (bus.op_a),
    .neg    (bus.op_a[WIDTH-1]),
    .result (absA)
  );

  mult_div_unit_sign_fix #(.W(WIDTH)) uAbsB (
    .value  (bus.op_b),
    .neg    (bus.op_b[WIDTH-1]),
    .result (absB)
  );

  // Low half of the accumulator holds the multiplier (mul) or dividend (div);
  // opndReg holds the multiplicand (mul) or divisor (div).
  assign accInit = {{(WIDTH+1){1'b0}}, (isMulIn ? absB : absA)};

  // Shift-add: conditionally add the multiplicand into the high half, shift right.
  assign mulSum  = accReg[ACC_W-1:WIDTH] +
                   (accReg[0] ? {1'b0, opndReg} : {(WIDTH+1){1'b0}});
  assign mulStep = {1'b0, mulSum, accReg[WIDTH-1:1]};

  // Restoring divide: shift left, trial subtract, keep only when it fits.
  assign divShifted = {accReg[ACC_W-2:0], 1'b0};
  assign divShiftHi = divShifted[ACC_W-1:WIDTH];
  assign divFits    = (divShiftHi >= {1'b0, opndReg});
  assign divDiff    = divShiftHi - {1'b0, opndReg};
  assign divStep    = divFits ? {divDiff, divShifted[WIDTH-1:1], 1'b1} : divShifted;

  assign accNext = isMulReg ? mulStep : divStep;

  // Results are taken from the final step's combinational value so they land
  // on the same edge that leaves RUN.
  mult_div_unit_sign_fix #(.W(2*WIDTH)) uProdFix (
    .value  (mulStep[2*WIDTH-1:0]),
    .neg    (signAReg ^ signBReg),
    .result (prodFixed)
  );

  mult_div_unit_sign_fix #(.W(WIDTH)) uQuotFix (
    .value  (divStep[WIDTH-1:0]),
    .neg    (signAReg ^ signBReg),
    .result (quotFixed)
  );

  mult_div_unit_sign_fix #(.W(WIDTH)) uRemFix (
    .value  (divStep[2*WIDTH-1:WIDTH]),
    .neg    (signAReg),
    .result (remFixed)
  );

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_IDLE: begin
        if (accept) stateNext = divZero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (lastIter) stateNext = S_DONE;
      end
      S_DONE: begin
        if (accept) stateNext = divZero ? S_DONE : S_RUN;
        else        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= S_IDLE;
      cntReg       <= '0;
      accReg       <= '0;
      opndReg      <= '0;
      isMulReg     <= 1'b0;
      signAReg     <= 1'b0;
      signBReg     <= 1'b0;
      resultLoReg  <= '0;
      resultHiReg  <= '0;
      divByZeroReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        cntReg       <= '0;
        accReg       <= accInit;
        opndReg      <= isMulIn ? absA : absB;
        isMulReg     <= isMulIn;
        signAReg     <= bus.op_a[WIDTH-1];
        signBReg     <= bus.op_b[WIDTH-1];
        divByZeroReg <= divZero;
        if (divZero) begin
          resultLoReg <= WIDTH'(DIV0_QUOT);
          resultHiReg <= bus.op_a;
        end
      end else if (stateReg == S_RUN) begin
        accReg <= accNext;
        if (cntReg != SAT_CNT) cntReg <= cntReg + CNT_BITS'(1);
        if (lastIter) begin
          resultLoReg <= isMulReg ? prodFixed[WIDTH-1:0]       : quotFixed;
          resultHiReg <= isMulReg ? prodFixed[2*WIDTH-1:WIDTH] : remFixed;
        end
      end
    end
  end

  assign bus.result_lo   = resultLoReg;
  assign bus.result_hi   = resultHiReg;
  assign bus.busy        = (stateReg == S_RUN);
  assign bus.done        = (stateReg == S_DONE);
  assign bus.div_by_zero = divByZeroReg;
  assign bus.stall       = (stateReg == S_RUN) | accept;

endmodule
